// File: rtl/vga_text_render.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// vga_text_render
//
// Purpose:
//   Turns a 1280x1024 raster position into pixels from a 160x64 text grid
//   of 8x16 cells. Each pixel takes one character RAM lookup and one font
//   ROM lookup. The pipeline is free-running and produces one pixel per
//   clock. The sync strobes are delayed so that they line up with the
//   colour outputs.
//
// Optional feature (macro CURSOR_BLINK_EN):
//   When this macro is defined, a frame counter counts falling edges of
//   vsync_in. While bit BLINK_LOG2-1 of that counter is set, the cursor
//   cell is drawn with foreground and background swapped. When the macro
//   is undefined, the cursor ports are ignored and no frame counter exists.
//
// Ports:
//   clk                      pixel clock; all logic runs on the rising edge
//   rst                      synchronous, active-high reset
//   h_in, v_in               raster position from the sync stage
//   hsync_in, vsync_in,
//   blank_in, sync_in        active-low strobes, one cycle behind h_in/v_in
//   char_addr                character RAM address (row*160 + col)
//   char_data                character code, valid the cycle after char_addr
//   font_addr                font ROM address {code, glyph row}
//   font_data                glyph row, valid the cycle after font_addr;
//                            bit 7 is the leftmost pixel
//   cursor_col, cursor_row   cursor cell
//   red, green, blue         pixel colour, valid 5 cycles after h_in/v_in
//   hsync_out, vsync_out,
//   blank_out, sync_out      delayed strobes, aligned with the colour
// ---------------------------------------------------------------------------
module vga_text_render #(
  parameter logic [23:0] FG_COLOR   = 24'hFFFFFF,
  parameter logic [23:0] BG_COLOR   = 24'h000000,
  parameter int          BLINK_LOG2 = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] h_in,
  input  logic [10:0] v_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        blank_in,
  input  logic        sync_in,
  output logic [13:0] char_addr,
  input  logic [7:0]  char_data,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  input  logic [7:0]  cursor_col,
  input  logic [5:0]  cursor_row,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        blank_out,
  output logic        sync_out
);

  // Cell coordinates and visibility of the incoming raster position
  logic [7:0]  w_col;
  logic [5:0]  w_row;
  logic        w_inside;
  logic [13:0] w_addr;

  assign w_col    = h_in[10:3];
  assign w_row    = v_in[9:4];
  assign w_inside = (h_in < 11'd1280) && (v_in < 11'd1024);

  // Compute row*160 as row*128 + row*32, which needs only two shifted adds
  assign w_addr = {1'b0, w_row, 7'b0} + {3'b0, w_row, 5'b0} + {6'b0, w_col};

  // Pipeline registers
  logic [13:0]      r_charAddr;
  logic [11:0]      r_fontAddr;
  logic [23:0]      r_rgb;
  logic [3:0]       r_insidePipe;
  logic [3:0][2:0]  r_hLowPipe;
  logic [1:0][3:0]  r_vLowPipe;
  logic [3:0]       r_hsyncPipe;
  logic [3:0]       r_vsyncPipe;
  logic [3:0]       r_blankPipe;
  logic [3:0]       r_syncPipe;

  logic w_swap;
  logic w_pixBit;
  logic w_fgSel;

  // Stage 1: register the character address. The glyph column and the
  // visibility flag travel alongside it so that they arrive at the pixel
  // stage together with font_data. The glyph row only needs to reach the
  // font address stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_charAddr   <= '0;
      r_insidePipe <= '0;
      r_hLowPipe   <= '0;
      r_vLowPipe   <= '0;
    end else begin
      r_charAddr   <= w_inside ? w_addr : 14'd0;
      r_insidePipe <= {r_insidePipe[2:0], w_inside};
      r_hLowPipe   <= {r_hLowPipe[2:0], h_in[2:0]};
      r_vLowPipe   <= {r_vLowPipe[0], v_in[3:0]};
    end
  end

  // Stage 3: char_data answers the address from the previous cycle. Join it
  // with the glyph row that has been delayed to the same point.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fontAddr <= '0;
    end else begin
      r_fontAddr <= {char_data, r_vLowPipe[1]};
    end
  end

  // Bit 7 is the leftmost pixel. For a 3-bit column, 7 - x equals ~x.
  assign w_pixBit = font_data[~r_hLowPipe[3]];
  assign w_fgSel  = w_pixBit ^ w_swap;

  // Stage 5: choose the colour. The third blank stage describes the same
  // position as font_data, because the strobes arrive one cycle later than
  // the position they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rgb <= '0;
    end else if (!r_insidePipe[3] || !r_blankPipe[2]) begin
      r_rgb <= '0;
    end else begin
      r_rgb <= w_fgSel ? FG_COLOR : BG_COLOR;
    end
  end

  // Four-cycle strobe delay. The syncs reset to their inactive level, and
  // blank resets to "blanking" so that the reset state reads as dark.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hsyncPipe <= 4'hF;
      r_vsyncPipe <= 4'hF;
      r_syncPipe  <= 4'hF;
      r_blankPipe <= 4'h0;
    end else begin
      r_hsyncPipe <= {r_hsyncPipe[2:0], hsync_in};
      r_vsyncPipe <= {r_vsyncPipe[2:0], vsync_in};
      r_syncPipe  <= {r_syncPipe[2:0], sync_in};
      r_blankPipe <= {r_blankPipe[2:0], blank_in};
    end
  end

`ifdef CURSOR_BLINK_EN
  logic                  r_vsyncPrev;
  logic [BLINK_LOG2-1:0] r_frameCnt;
  logic [3:0]            r_cursorPipe;
  logic                  w_cursorHit;

  assign w_cursorHit = (w_col == cursor_col) && (w_row == cursor_row);

  // Count falling edges of vsync_in. The counter is only as wide as the
  // blink bit, so it simply wraps and the cursor phase keeps toggling.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vsyncPrev  <= 1'b1;
      r_frameCnt   <= '0;
      r_cursorPipe <= '0;
    end else begin
      r_vsyncPrev  <= vsync_in;
      r_cursorPipe <= {r_cursorPipe[2:0], w_cursorHit};
      if (r_vsyncPrev && !vsync_in) begin
        r_frameCnt <= r_frameCnt + 1'b1;
      end
    end
  end

  assign w_swap = r_cursorPipe[3] & r_frameCnt[BLINK_LOG2-1];
`else
  logic w_unusedCursor;

  assign w_unusedCursor = ^{cursor_col, cursor_row, (BLINK_LOG2 > 0)};
  assign w_swap         = 1'b0;
`endif

  assign char_addr = r_charAddr;
  assign font_addr = r_fontAddr;
  assign red       = r_rgb[23:16];
  assign green     = r_rgb[15:8];
  assign blue      = r_rgb[7:0];
  assign hsync_out = r_hsyncPipe[3];
  assign vsync_out = r_vsyncPipe[3];
  assign blank_out = r_blankPipe[3];
  assign sync_out  = r_syncPipe[3];

endmodule
